// File: rtl/plic_priority_index_pipe.sv
// Pipelined PLIC priority-index search with a per-sample threshold compare.
// Define PLIC_PRIORITY_INDEX_LOCK_EN to add per-source claim/complete locking.
module plic_priority_index_pipe #(
  parameter int SOURCES       = 64,
  parameter int PRIORITIES    = 7,
  parameter int REG_LEVELS    = 2,
  parameter int SOURCES_BITS  = $clog2(SOURCES + 1),
  parameter int PRIORITY_BITS = $clog2(PRIORITIES)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    en_i,
  input  logic                                    clear_i,
  input  logic                                    valid_i,
  input  logic [SOURCES-1:0]                      pending_i,
  input  logic [SOURCES-1:0]                      ie_i,
  input  logic [SOURCES-1:0][PRIORITY_BITS-1:0]   priority_i,
  input  logic [PRIORITY_BITS-1:0]                threshold_i,
`ifdef PLIC_PRIORITY_INDEX_LOCK_EN
  input  logic                                    claim_i,
  input  logic                                    complete_i,
  input  logic [SOURCES_BITS-1:0]                 complete_id_i,
  output logic [SOURCES-1:0]                      claimed_o,
`endif
  output logic                                    valid_o,
  output logic [SOURCES_BITS-1:0]                 id_o,
  output logic [PRIORITY_BITS-1:0]                priority_o,
  output logic                                    ireq_o
);

  localparam int LEVELS = $clog2(SOURCES);
  localparam int NLEAF  = 1 << LEVELS;
  localparam int NODES  = 2 * NLEAF - 1;
  localparam int NREG   = (LEVELS >= 1 && REG_LEVELS > 0) ? (LEVELS - 1) / REG_LEVELS : 0;
  localparam int RL_DIV = (REG_LEVELS > 0) ? REG_LEVELS : 1;

  // Nodes are stored level by level: leaves first, root last.
  function automatic int lvl_off(input int l);
    return 2 * NLEAF - ((2 * NLEAF) >> l);
  endfunction

  function automatic logic lvl_reg(input int l);
    return (REG_LEVELS > 0) && (l >= 1) && (l <= LEVELS - 1) && ((l % RL_DIV) == 0);
  endfunction

  logic [SOURCES-1:0]       w_eligible;
  logic [PRIORITY_BITS-1:0] w_pri [NODES];
  logic [SOURCES_BITS-1:0]  w_id  [NODES];
  logic [PRIORITY_BITS-1:0] r_pri [NODES];
  logic [SOURCES_BITS-1:0]  r_id  [NODES];
  logic                     w_root_vld;
  logic [PRIORITY_BITS-1:0] w_root_thr;

  logic                     r_vld_o;
  logic [SOURCES_BITS-1:0]  r_id_o;
  logic [PRIORITY_BITS-1:0] r_pri_o;
  logic                     r_ireq_o;

`ifdef PLIC_PRIORITY_INDEX_LOCK_EN
  logic [SOURCES-1:0] r_claimed;

  assign w_eligible = pending_i & ie_i & ~r_claimed;
  assign claimed_o  = r_claimed;

  // Complete takes precedence over a same-cycle claim of the same ID.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_claimed <= '0;
    end else begin
      for (int n = 0; n < SOURCES; n++) begin
        if (complete_i && (complete_id_i == SOURCES_BITS'(n + 1)))
          r_claimed[n] <= 1'b0;
        else if (claim_i && r_vld_o && (r_id_o == SOURCES_BITS'(n + 1)))
          r_claimed[n] <= 1'b1;
      end
    end
  end
`else
  assign w_eligible = pending_i & ie_i;
`endif

  always_comb begin
    int                       lo_idx;
    int                       dst_idx;
    logic [PRIORITY_BITS-1:0] pri_lo;
    logic [PRIORITY_BITS-1:0] pri_hi;
    logic [SOURCES_BITS-1:0]  id_lo;
    logic [SOURCES_BITS-1:0]  id_hi;
    lo_idx  = 0;
    dst_idx = 0;
    pri_lo  = '0;
    pri_hi  = '0;
    id_lo   = '0;
    id_hi   = '0;
    for (int n = 0; n < NODES; n++) begin
      w_pri[n] = '0;
      w_id[n]  = '0;
    end
    // Zero-priority leaves carry ID 0 so an empty search resolves to "none".
    for (int s = 0; s < SOURCES; s++) begin
      if (w_eligible[s] && (priority_i[s] != '0)) begin
        w_pri[s] = priority_i[s];
        w_id[s]  = SOURCES_BITS'(s + 1);
      end
    end
    for (int l = 1; l <= LEVELS; l++) begin
      for (int p = 0; p < (NLEAF >> l); p++) begin
        lo_idx  = lvl_off(l - 1) + 2 * p;
        dst_idx = lvl_off(l) + p;
        pri_lo  = lvl_reg(l - 1) ? r_pri[lo_idx]     : w_pri[lo_idx];
        pri_hi  = lvl_reg(l - 1) ? r_pri[lo_idx + 1] : w_pri[lo_idx + 1];
        id_lo   = lvl_reg(l - 1) ? r_id[lo_idx]      : w_id[lo_idx];
        id_hi   = lvl_reg(l - 1) ? r_id[lo_idx + 1]  : w_id[lo_idx + 1];
        if (pri_hi > pri_lo) begin
          w_pri[dst_idx] = pri_hi;
          w_id[dst_idx]  = id_hi;
        end else begin
          w_pri[dst_idx] = pri_lo;
          w_id[dst_idx]  = id_lo;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int n = 0; n < NODES; n++) begin
        r_pri[n] <= '0;
        r_id[n]  <= '0;
      end
    end else if (en_i) begin
      for (int l = 1; l < LEVELS; l++) begin
        if (lvl_reg(l)) begin
          for (int p = 0; p < (NLEAF >> l); p++) begin
            r_pri[lvl_off(l) + p] <= w_pri[lvl_off(l) + p];
            r_id[lvl_off(l) + p]  <= w_id[lvl_off(l) + p];
          end
        end
      end
    end
  end

  // Valid and threshold travel alongside the tree registers.
  if (NREG > 0) begin : g_stage
    logic                     r_vld [NREG];
    logic [PRIORITY_BITS-1:0] r_thr [NREG];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int k = 0; k < NREG; k++) begin
          r_vld[k] <= 1'b0;
          r_thr[k] <= '0;
        end
      end else begin
        if (clear_i) begin
          for (int k = 0; k < NREG; k++) r_vld[k] <= 1'b0;
        end else if (en_i) begin
          r_vld[0] <= valid_i;
          for (int k = 1; k < NREG; k++) r_vld[k] <= r_vld[k - 1];
        end
        if (en_i) begin
          r_thr[0] <= threshold_i;
          for (int k = 1; k < NREG; k++) r_thr[k] <= r_thr[k - 1];
        end
      end
    end

    assign w_root_vld = r_vld[NREG - 1];
    assign w_root_thr = r_thr[NREG - 1];
  end else begin : g_nostage
    assign w_root_vld = valid_i;
    assign w_root_thr = threshold_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vld_o  <= 1'b0;
      r_id_o   <= '0;
      r_pri_o  <= '0;
      r_ireq_o <= 1'b0;
    end else begin
      if (clear_i)
        r_vld_o <= 1'b0;
      else if (en_i)
        r_vld_o <= w_root_vld;
      if (en_i) begin
        r_id_o   <= w_id[NODES - 1];
        r_pri_o  <= w_pri[NODES - 1];
        r_ireq_o <= (w_pri[NODES - 1] > w_root_thr);
      end
    end
  end

  assign valid_o    = r_vld_o;
  assign id_o       = r_id_o;
  assign priority_o = r_pri_o;
  assign ireq_o     = r_ireq_o;

endmodule

// File: tb/tb_plic_priority_index_pipe.sv
// Scoreboard bench: two 16-source pipes (REG_LEVELS 2 and 1) driven in parallel.
// Lock checks are compiled in when PLIC_PRIORITY_INDEX_LOCK_EN is defined.
module tb_plic_priority_index_pipe;
  localparam int S    = 16;
  localparam int PB   = 3;
  localparam int SB   = 5;
  localparam int LAT0 = 2;
  localparam int LAT1 = 4;

  typedef struct packed {
    logic [SB-1:0] id;
    logic [PB-1:0] pri;
    logic          ireq;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, en, clr, vin;
  logic [S-1:0]         pend, ie;
  logic [S-1:0][PB-1:0] prio;
  logic [PB-1:0]        thr;
  logic                 vo0, ir0, vo1, ir1;
  logic [SB-1:0]        id0, id1;
  logic [PB-1:0]        po0, po1;
  logic [S-1:0]         lock_m;
`ifdef PLIC_PRIORITY_INDEX_LOCK_EN
  logic                 claim, compl;
  logic [SB-1:0]        cid;
  logic [S-1:0]         cl0, cl1;
`endif

  exp_t       q0[$];
  exp_t       q1[$];
  exp_t       cur0, cur1;
  logic [7:0] vp0, vp1;
  int         total = 0;
  int         bad   = 0;

  plic_priority_index_pipe #(.SOURCES(S), .PRIORITIES(7), .REG_LEVELS(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clr), .valid_i(vin),
    .pending_i(pend), .ie_i(ie), .priority_i(prio), .threshold_i(thr),
`ifdef PLIC_PRIORITY_INDEX_LOCK_EN
    .claim_i(claim), .complete_i(compl), .complete_id_i(cid), .claimed_o(cl0),
`endif
    .valid_o(vo0), .id_o(id0), .priority_o(po0), .ireq_o(ir0)
  );

  plic_priority_index_pipe #(.SOURCES(S), .PRIORITIES(7), .REG_LEVELS(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clr), .valid_i(vin),
    .pending_i(pend), .ie_i(ie), .priority_i(prio), .threshold_i(thr),
`ifdef PLIC_PRIORITY_INDEX_LOCK_EN
    .claim_i(1'b0), .complete_i(1'b0), .complete_id_i('0), .claimed_o(cl1),
`endif
    .valid_o(vo1), .id_o(id1), .priority_o(po1), .ireq_o(ir1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Highest eligible priority wins; scanning upward with strict > keeps the lowest ID on ties.
  function automatic exp_t golden(input logic [S-1:0] p, input logic [S-1:0] e,
                                  input logic [S-1:0] lk, input logic [S-1:0][PB-1:0] pr,
                                  input logic [PB-1:0] th);
    exp_t r;
    r = '0;
    for (int n = 0; n < S; n++)
      if (p[n] && e[n] && !lk[n] && (pr[n] > r.pri)) begin
        r.pri = pr[n];
        r.id  = SB'(n + 1);
      end
    r.ireq = (r.pri > th);
    return r;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_v0"},   32'(vo0), 0);
    check({tag, "_id0"},  32'(id0), 0);
    check({tag, "_pri0"}, 32'(po0), 0);
    check({tag, "_irq0"}, 32'(ir0), 0);
    check({tag, "_v1"},   32'(vo1), 0);
    check({tag, "_id1"},  32'(id1), 0);
    check({tag, "_pri1"}, 32'(po1), 0);
    check({tag, "_irq1"}, 32'(ir1), 0);
  endtask

  task automatic step(input logic v, input logic e, input logic c);
    @(negedge clk);
    vin = v;
    en  = e;
    clr = c;
    if (c) begin
      q0.delete();
      q1.delete();
    end else if (v && e) begin
      q0.push_back(golden(pend, ie, lock_m, prio, thr));
      q1.push_back(golden(pend, ie, '0, prio, thr));
    end
    @(posedge clk);
    #1;
`ifdef PLIC_PRIORITY_INDEX_LOCK_EN
    for (int n = 0; n < S; n++) begin
      if (compl && (cid == SB'(n + 1)))
        lock_m[n] = 1'b0;
      else if (claim && vp0[LAT0-1] && (cur0.id == SB'(n + 1)))
        lock_m[n] = 1'b1;
    end
`endif
    if (c) begin
      vp0 = '0;
      vp1 = '0;
    end else if (e) begin
      vp0 = {vp0[6:0], v};
      vp1 = {vp1[6:0], v};
      if (vp0[LAT0-1]) begin
        check("sb0_avail", 32'(q0.size() != 0), 1);
        if (q0.size() != 0) cur0 = q0.pop_front();
        $display("dut0 out id=%0d pri=%0d ireq=%0d", cur0.id, cur0.pri, cur0.ireq);
      end
      if (vp1[LAT1-1]) begin
        check("sb1_avail", 32'(q1.size() != 0), 1);
        if (q1.size() != 0) cur1 = q1.pop_front();
        $display("dut1 out id=%0d pri=%0d ireq=%0d", cur1.id, cur1.pri, cur1.ireq);
      end
    end
    check("valid0", 32'(vo0), 32'(vp0[LAT0-1]));
    if (vp0[LAT0-1]) begin
      check("id0",  32'(id0), 32'(cur0.id));
      check("pri0", 32'(po0), 32'(cur0.pri));
      check("irq0", 32'(ir0), 32'(cur0.ireq));
    end
    check("valid1", 32'(vo1), 32'(vp1[LAT1-1]));
    if (vp1[LAT1-1]) begin
      check("id1",  32'(id1), 32'(cur1.id));
      check("pri1", 32'(po1), 32'(cur1.pri));
      check("irq1", 32'(ir1), 32'(cur1.ireq));
    end
`ifdef PLIC_PRIORITY_INDEX_LOCK_EN
    check("claimed0", 32'(cl0), 32'(lock_m));
    check("claimed1", 32'(cl1), 0);
`endif
  endtask

  task automatic set_a();
    pend = '0;
    ie   = '1;
    prio = '0;
    pend[3] = 1'b1; prio[3] = 3'd5;
    pend[9] = 1'b1; prio[9] = 3'd5;
    pend[12] = 1'b1; prio[12] = 3'd2;
    thr = 3'd4;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; vin = 1'b0;
    pend = '0; ie = '0; prio = '0; thr = '0;
    lock_m = '0; cur0 = '0; cur1 = '0; vp0 = '0; vp1 = '0;
`ifdef PLIC_PRIORITY_INDEX_LOCK_EN
    claim = 1'b0; compl = 1'b0; cid = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Priority, tie-break, threshold and masking
    set_a();
    step(1, 1, 0);
    thr = 3'd5;
    step(1, 1, 0);
    thr = 3'd4; ie[3] = 1'b0; ie[9] = 1'b0;
    step(1, 1, 0);
    pend = '0;
    step(1, 1, 0);

    // Back-to-back winners 7, 2, 15
    ie = '1; thr = 3'd2; prio = '0;
    pend = '0; pend[6] = 1'b1; prio[6] = 3'd3;
    step(1, 1, 0);
    pend = '0; pend[1] = 1'b1; prio[1] = 3'd7; pend[5] = 1'b1; prio[5] = 3'd6;
    step(1, 1, 0);
    pend = '0; pend[14] = 1'b1; prio[14] = 3'd7; pend[2] = 1'b1; prio[2] = 3'd6;
    step(1, 1, 0);
    repeat (5) step(0, 1, 0);

    // Random samples with random gaps and stalls
    for (int i = 0; i < 30; i++) begin
      pend = S'($urandom);
      ie   = S'($urandom);
      for (int n = 0; n < S; n++) prio[n] = PB'($urandom_range(0, 7));
      thr = PB'($urandom_range(0, 7));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, 1'b0);
    end
    repeat (6) step(0, 1, 0);

    // Stall with a result sitting at the output
    set_a();
    step(1, 1, 0);
    thr = 3'd5;
    step(1, 1, 0);
    repeat (3) step(1, 0, 0);
    repeat (5) step(0, 1, 0);

    // Flush in flight, and flush while stalled
    set_a();
    step(1, 1, 0);
    step(1, 1, 1);
    repeat (5) step(0, 1, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    repeat (5) step(0, 1, 0);

    // Asynchronous reset mid-stream
    set_a();
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    q0.delete(); q1.delete();
    vp0 = '0; vp1 = '0; lock_m = '0;
    rst = 1'b0;
    repeat (5) step(0, 1, 0);

`ifdef PLIC_PRIORITY_INDEX_LOCK_EN
    // Claim id 4, then complete it, then claim and complete together
    set_a();
    step(1, 1, 0);
    step(0, 1, 0);
    claim = 1'b1;
    step(1, 1, 0);
    claim = 1'b0;
    step(1, 1, 0);
    repeat (3) step(0, 1, 0);
    compl = 1'b1; cid = SB'(4);
    step(1, 1, 0);
    compl = 1'b0;
    step(1, 1, 0);
    step(0, 1, 0);
    claim = 1'b1; compl = 1'b1; cid = SB'(4);
    step(1, 1, 0);
    claim = 1'b0; compl = 1'b0;
    repeat (5) step(0, 1, 0);
`endif

    check("sb0_empty", 32'(q0.size()), 0);
    check("sb1_empty", 32'(q1.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/plic_priority_index_pipe.md
Name: plic_priority_index_pipe

Overview:
- Pipelined successor to the combinational PLIC priority-index tree.
- Masks each source by its pending and enable bits, then searches all SOURCES for the highest priority and its ID.
- Compares the winning priority against a per-target threshold and registers the result.
- Sits in a PLIC target between the gateway/enable registers and the claim/ireq logic.
- The depth is configurable, so large SOURCES counts meet timing.

Parameters:
- SOURCES, 64: number of interrupt sources, 1+.
- PRIORITIES, 7: number of priority levels, 1+.
- REG_LEVELS, 2: tree levels between internal pipeline registers; 0 means no internal registers.
- SOURCES_BITS, $clog2(SOURCES+1): ID width; ID 0 is reserved for "none".
- PRIORITY_BITS, $clog2(PRIORITIES): priority width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- en_i  in  1  pipeline advance; when 0, every register holds.
- clear_i  in  1  synchronous flush of all valid bits.
- valid_i  in  1  input sample valid.
- pending_i  in  SOURCES  pending bit per source; bit n is ID n+1.
- ie_i  in  SOURCES  interrupt-enable bit per source.
- priority_i  in  [PRIORITY_BITS-1:0] x SOURCES  priority per source.
- threshold_i  in  PRIORITY_BITS  target threshold.
- valid_o  out  1  result valid.
- id_o  out  SOURCES_BITS  winning ID; 0 if none.
- priority_o  out  PRIORITY_BITS  winning priority.
- ireq_o  out  1  interrupt request, priority_o > threshold of the same sample.

Behaviour:
- Reset: all pipeline registers clear immediately. Outputs read valid_o=0, id_o=0, priority_o=0, ireq_o=0.
- Masking: effective priority is priority_i[n] only if pending_i[n] & ie_i[n], otherwise 0. A priority-0 source never wins.
- Tree:
  - LEVELS = $clog2(SOURCES) binary compare levels.
  - Each node selects the hi branch only if priority_hi > priority_lo. Ties therefore go to the lower ID.
  - Unused leaves (SOURCES not a power of 2) carry priority 0 and ID 0.
- Registers:
  - A pipeline register follows every level k (1..LEVELS-1) where k mod REG_LEVELS == 0.
  - A final output register is always present.
  - Latency LAT = 1 + floor((LEVELS-1)/REG_LEVELS) cycles when LEVELS ≥ 1 and REG_LEVELS > 0; otherwise LAT = 1.
  - Examples: SOURCES=16 gives 2 with REG_LEVELS=2 and 4 with REG_LEVELS=1; SOURCES=1 gives 1.
- Threshold: threshold_i is captured with valid_i and travels with its sample. A later threshold change never affects an in-flight result.
- Valid: each stage carries a valid bit. Data registers load every enabled cycle, regardless of valid. Outputs with valid_o=0 are don't-care, except after reset or clear.
- en_i=0: the whole pipe freezes, including valid bits; input that cycle is dropped. No backpressure output; the upstream owner gates valid_i.
- clear_i=1: all valid bits go to 0 next cycle. The same-cycle valid_i is also discarded. clear_i overrides en_i=0. Data registers are untouched.
- Result 0: no eligible source gives id_o=0, priority_o=0, ireq_o=0.
- Throughput: one sample per enabled cycle; back-to-back samples emerge in order.

Optional Feature:
- Macro: PLIC_PRIORITY_INDEX_LOCK_EN.
- When defined, adds these ports:
  - claim_i (1): claim strobe.
  - complete_i (1): complete strobe.
  - complete_id_i (SOURCES_BITS): ID being completed.
  - claimed_o (SOURCES): claimed bit per source.
- claim_i with valid_o=1 and id_o≠0 sets claimed_o[id_o-1]. Sources with claimed set are masked to priority 0 at tree input.
- complete_i clears claimed_o[complete_id_i-1]. complete_id_i of 0 or above SOURCES is ignored.
- Same-cycle claim and complete on the same ID: complete wins, and the bit ends cleared.
- claimed_o resets to 0.
- Without the macro: these ports and registers do not exist, and masking is pending&ie only.

Test Plan:
- Priority and tie-break (SOURCES=16, REG_LEVELS=2): sources 3, 9 and 12 pending+enabled with priorities 5, 5, 2, threshold 4, valid_i=1 → after 2 cycles valid_o=1, id_o=4, priority_o=5, ireq_o=1.
- Threshold and masking: same sample with threshold 5 → ireq_o=0, id_o=4. With ie_i[3]=0 and ie_i[9]=0 → id_o=13, priority_o=2, ireq_o=0.
- Stall: en_i=0 for 3 cycles mid-flight → outputs frozen during the stall; result appears LAT enabled cycles after valid_i.
- Flush and reset: clear_i during an in-flight sample → valid_o stays 0. Assert rst_i mid-stream → valid_o, id_o and ireq_o drop to 0 without a clock edge.
- Pipeline order and latency: REG_LEVELS=1, back-to-back samples with IDs 7, 2, 15 winning → outputs 7, 2, 15 on consecutive cycles after 4-cycle latency. Also no eligible source → id_o=0, priority_o=0, ireq_o=0.
- With PLIC_PRIORITY_INDEX_LOCK_EN, claim/complete:
  - Claim while id_o=4 → claimed_o[3]=1, and next results select id 10.
  - complete_id_i=4 → source 4 wins again.
  - Simultaneous claim and complete of ID 4 → claimed_o[3]=0.
